// File: rtl/reset_sequencer.sv
// Staged reset release sequencer: holds all downstream stages in reset, then
// releases them one by one (bit 0 first) and replays on soft-reset requests.
module reset_sequencer #(
    parameter int STAGES      = 3,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req,
    output logic [1:0]        req_ack,
    output logic [STAGES-1:0] stage_rst,
    output logic              busy,
    output logic [1:0]        cause
);

    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (STAGES > 1) ? $clog2(STAGES) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(STAGES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        GAP  = 2'd1,
        IDLE = 2'd2
    } state_t;

    state_t            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [IDX_W-1:0]  idx_r;
    logic [STAGES-1:0] stage_rst_r;
    logic              busy_r;
    logic [1:0]        req_ack_r;
    logic [1:0]        cause_r;

    // Sequencer FSM with all outputs registered.
    // Stages release LSB first, so a left shift clears the next stage and keeps
    // the 1...10...0 ordering by construction; busy tracks the post-shift value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= HOLD;
            cnt_r       <= '0;
            idx_r       <= '0;
            stage_rst_r <= '1;
            busy_r      <= 1'b1;
            req_ack_r   <= 2'b00;
            cause_r     <= 2'b00;
        end else begin
            case (state_r)
                HOLD: begin
                    req_ack_r <= 2'b00;
                    if (cnt_r == HOLD_LAST) begin
                        cnt_r       <= '0;
                        stage_rst_r <= stage_rst_r << 1'b1;
                        busy_r      <= |(stage_rst_r << 1'b1);
                        if (STAGES == 1) begin
                            state_r <= IDLE;
                            idx_r   <= '0;
                        end else begin
                            state_r <= GAP;
                            idx_r   <= IDX_ONE;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                GAP: begin
                    req_ack_r <= 2'b00;
                    if (cnt_r == GAP_LAST) begin
                        cnt_r       <= '0;
                        stage_rst_r <= stage_rst_r << 1'b1;
                        busy_r      <= |(stage_rst_r << 1'b1);
                        if (idx_r == IDX_LAST) begin
                            state_r <= IDLE;
                            idx_r   <= '0;
                        end else begin
                            idx_r <= idx_r + IDX_ONE;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                IDLE: begin
                    // Requests are only looked at here, never latched while busy.
                    if (req != 2'b00) begin
                        req_ack_r   <= req;
                        cause_r     <= req;
                        stage_rst_r <= '1;
                        busy_r      <= 1'b1;
                        state_r     <= HOLD;
                        cnt_r       <= '0;
                        idx_r       <= '0;
                    end else begin
                        req_ack_r <= 2'b00;
                    end
                end
                default: begin
                    state_r     <= HOLD;
                    cnt_r       <= '0;
                    idx_r       <= '0;
                    stage_rst_r <= '1;
                    busy_r      <= 1'b1;
                    req_ack_r   <= 2'b00;
                end
            endcase
        end
    end

    assign req_ack   = req_ack_r;
    assign stage_rst = stage_rst_r;
    assign busy      = busy_r;
    assign cause     = cause_r;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: vector table through a scoreboard on the default
// instance, plus hand-written async-reset and parameter-sweep sequences.
module tb_reset_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance
    logic       rst_n_a = 1'b0;
    logic [1:0] req_a   = 2'b00;
    logic [1:0] ack_a;
    logic [2:0] stage_a;
    logic       busy_a;
    logic [1:0] cause_a;

    // STAGES=1, HOLD=1, GAP=1
    logic       rst_n_b = 1'b0;
    logic [1:0] req_b   = 2'b00;
    logic [1:0] ack_b;
    logic [0:0] stage_b;
    logic       busy_b;
    logic [1:0] cause_b;

    // STAGES=8, HOLD=2, GAP=3
    logic       rst_n_c = 1'b0;
    logic [1:0] req_c   = 2'b00;
    logic [1:0] ack_c;
    logic [7:0] stage_c;
    logic       busy_c;
    logic [1:0] cause_c;

    reset_sequencer #(.STAGES(3), .HOLD_CYCLES(4), .GAP_CYCLES(2)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .req(req_a), .req_ack(ack_a),
        .stage_rst(stage_a), .busy(busy_a), .cause(cause_a)
    );
    reset_sequencer #(.STAGES(1), .HOLD_CYCLES(1), .GAP_CYCLES(1)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .req(req_b), .req_ack(ack_b),
        .stage_rst(stage_b), .busy(busy_b), .cause(cause_b)
    );
    reset_sequencer #(.STAGES(8), .HOLD_CYCLES(2), .GAP_CYCLES(3)) dut_c (
        .clk(clk), .rst_n(rst_n_c), .req(req_c), .req_ack(ack_c),
        .stage_rst(stage_c), .busy(busy_c), .cause(cause_c)
    );

    typedef struct {
        logic       rst_n;
        logic [1:0] req;
        logic [2:0] stage;
        logic       busy;
        logic [1:0] ack;
        logic [1:0] cause;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Stage k is still in reset t edges after sequence start iff t < hold + k*gap.
    function automatic logic [7:0] exp_stage(input int t, input int hold, input int gap, input int stages);
        logic [7:0] s;
        s = 8'h00;
        for (int k = 0; k < stages; k++) begin
            s[k] = (t < hold + k * gap);
        end
        return s;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic [1:0] q, input int t,
                       input logic [1:0] a, input logic [1:0] c);
        vec_t       v;
        logic [7:0] s;
        s       = exp_stage(t, 4, 2, 3);
        v.rst_n = r;
        v.req   = q;
        v.stage = s[2:0];
        v.busy  = |s;
        v.ack   = a;
        v.cause = c;
        vecs.push_back(v);
    endtask

    task automatic add_power_on(input int low_cycles);
        for (int i = 0; i < low_cycles; i++) add(1'b0, 2'b00, 0, 2'b00, 2'b00);
        for (int n = 1; n <= 9; n++) add(1'b1, 2'b00, n, 2'b00, 2'b00);
    endtask

    task automatic run_vectors();
        vec_t v;
        vec_t e;
        while (vecs.size() > 0) begin
            v = vecs.pop_front();
            @(negedge clk);
            rst_n_a = v.rst_n;
            req_a   = v.req;
            exp_q.push_back(v);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            chk("a_stage", 8'(stage_a), 8'(e.stage));
            chk("a_busy",  8'(busy_a),  8'(e.busy));
            chk("a_ack",   8'(ack_a),   8'(e.ack));
            chk("a_cause", 8'(cause_a), 8'(e.cause));
        end
    endtask

    initial begin : main
        logic [7:0] s;
        logic [7:0] inv;

        // Reset state of the sweep instances
        repeat (2) @(posedge clk);
        #1;
        chk("b_rst_stage", 8'(stage_b), 8'h01);
        chk("b_rst_busy",  8'(busy_b),  8'h01);
        chk("c_rst_stage", 8'(stage_c), 8'hFF);
        chk("c_rst_ack",   8'(ack_c),   8'h00);

        // Power-on, soft, simultaneous, held-request retrigger, request while busy
        add_power_on(3);
        add(1'b1, 2'b01, 0, 2'b01, 2'b01);
        for (int t = 1; t <= 9; t++) add(1'b1, 2'b00, t, 2'b00, 2'b01);
        add(1'b1, 2'b11, 0, 2'b11, 2'b11);
        for (int t = 1; t <= 9; t++) add(1'b1, 2'b00, t, 2'b00, 2'b11);
        add(1'b1, 2'b01, 0, 2'b01, 2'b01);
        for (int t = 1; t <= 8; t++) add(1'b1, 2'b01, t, 2'b00, 2'b01);
        add(1'b1, 2'b01, 0, 2'b01, 2'b01);
        for (int t = 1; t <= 9; t++) add(1'b1, 2'b00, t, 2'b00, 2'b01);
        for (int i = 0; i < 3; i++) add(1'b0, 2'b00, 0, 2'b00, 2'b00);
        for (int n = 1; n <= 4; n++) add(1'b1, 2'b00, n, 2'b00, 2'b00);
        for (int n = 5; n <= 8; n++) add(1'b1, 2'b10, n, 2'b00, 2'b00);
        add(1'b1, 2'b10, 0, 2'b10, 2'b10);
        for (int t = 1; t <= 9; t++) add(1'b1, 2'b00, t, 2'b00, 2'b10);
        run_vectors();

        // rst_n asserted at edge 6 of a soft sequence
        add(1'b1, 2'b01, 0, 2'b01, 2'b01);
        for (int t = 1; t <= 6; t++) add(1'b1, 2'b00, t, 2'b00, 2'b01);
        run_vectors();
        #1;
        rst_n_a = 1'b0;
        #1;
        chk("async_stage", 8'(stage_a), 8'h07);
        chk("async_busy",  8'(busy_a),  8'h01);
        chk("async_cause", 8'(cause_a), 8'h00);
        chk("async_ack",   8'(ack_a),   8'h00);
        add_power_on(2);
        run_vectors();

        // rst_n during the ack pulse cancels it
        add(1'b1, 2'b10, 0, 2'b10, 2'b10);
        run_vectors();
        #1;
        rst_n_a = 1'b0;
        #1;
        chk("cancel_ack",   8'(ack_a),   8'h00);
        chk("cancel_cause", 8'(cause_a), 8'h00);
        chk("cancel_stage", 8'(stage_a), 8'h07);
        add_power_on(2);
        run_vectors();

        // STAGES=1, HOLD=1, GAP=1
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            rst_n_b = 1'b1;
            @(posedge clk);
            #1;
            s = exp_stage(n, 1, 1, 1);
            chk("b_stage", 8'(stage_b), 8'(s[0]));
            chk("b_busy",  8'(busy_b),  8'(s[0]));
            chk("b_ack",   8'(ack_b),   8'h00);
        end
        @(negedge clk);
        req_b = 2'b10;
        @(posedge clk);
        #1;
        chk("b_soft_stage", 8'(stage_b), 8'h01);
        chk("b_soft_ack",   8'(ack_b),   8'h02);
        chk("b_soft_cause", 8'(cause_b), 8'h02);
        @(negedge clk);
        req_b = 2'b00;
        @(posedge clk);
        #1;
        chk("b_rel_stage", 8'(stage_b), 8'h00);
        chk("b_rel_busy",  8'(busy_b),  8'h00);
        chk("b_rel_ack",   8'(ack_b),   8'h00);

        // STAGES=8, HOLD=2, GAP=3: releases at edges 2,5,...,23
        for (int n = 1; n <= 26; n++) begin
            @(negedge clk);
            rst_n_c = 1'b1;
            @(posedge clk);
            #1;
            s   = exp_stage(n, 2, 3, 8);
            inv = ~stage_c;
            chk("c_stage", stage_c, s);
            chk("c_busy",  8'(busy_c), 8'(|s));
            chk("c_order", 8'((inv & (inv + 8'd1)) == 8'd0), 8'h01);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
